// File: rtl/conv_pkg.sv
// Shared widths, layer-memory select codes and command types for the conv/pool engines
// and the layer-memory arbiter.
package conv_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 20;
   localparam int SEL_W  = 3;

   localparam logic [SEL_W-1:0] L0_SEL = 3'd1;
   localparam logic [SEL_W-1:0] L1_SEL = 3'd3;

   // One past the last raster address of a 64x64 map; l0_count saturates here.
   localparam logic [ADDR_W:0] L0_FULL = 13'd4096;

   typedef enum logic {
      FAVOR_R0 = 1'b0,
      FAVOR_R1 = 1'b1
   } rr_ptr_t;

   typedef struct packed {
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

   // A read of L0 must not overtake the conv engine's raster-order writes.
   function automatic logic raw_blocked(input logic we, input logic [SEL_W-1:0] sel,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W:0] count);
      return !we && (sel == L0_SEL) && ({1'b0, addr} >= count);
   endfunction

endpackage

// File: rtl/layer_mem_rr_pick.sv
// Two-way round-robin picker: a lone eligible requester wins at once, and on a tie
// the requester that was not granted last wins.
module layer_mem_rr_pick
   import conv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] eligible,
   output logic [1:0] gnt
);

   rr_ptr_t    ptr;
   rr_ptr_t    ptr_next;
   logic [1:0] cand;

   always_ff @(posedge clk) begin
      if (!reset) ptr <= FAVOR_R0;
      else        ptr <= ptr_next;
   end

   always_comb begin
      cand     = req & eligible;
      gnt      = 2'b00;
      ptr_next = ptr;
      if (cand == 2'b11) gnt = (ptr == FAVOR_R0) ? 2'b01 : 2'b10;
      else               gnt = cand;
      if (gnt[0])      ptr_next = FAVOR_R1;
      else if (gnt[1]) ptr_next = FAVOR_R0;
   end

endmodule

// File: rtl/layer_mem_arbiter.sv
// Shares the single layer-memory port between the conv engine (R0, writes L0) and the
// max-pool engine (R1), with a raster-order read-after-write guard on L0.
module layer_mem_arbiter
   import conv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              r0_req,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [SEL_W-1:0]  r1_sel,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [SEL_W-1:0]  csel,
   output logic              crd,
   output logic [ADDR_W-1:0] caddr_rd,
   input  logic [DATA_W-1:0] cdata_rd,
   output logic              cwr,
   output logic [ADDR_W-1:0] caddr_wr,
   output logic [DATA_W-1:0] cdata_wr,
   output logic [ADDR_W:0]   l0_count
);

   mem_cmd_t   r0_cmd;
   mem_cmd_t   r1_cmd;
   mem_cmd_t   win_cmd;
   logic       r1_blocked;
   logic [1:0] gnt;

   always_comb begin
      r0_cmd     = '{we: 1'b1, sel: L0_SEL, addr: r0_addr, wdata: r0_wdata};
      r1_cmd     = '{we: r1_we, sel: r1_sel, addr: r1_addr, wdata: r1_wdata};
      r1_blocked = raw_blocked(r1_we, r1_sel, r1_addr, l0_count);
      win_cmd    = gnt[1] ? r1_cmd : r0_cmd;
   end

   layer_mem_rr_pick u_pick (
      .clk      (clk),
      .reset    (reset),
      .req      ({r1_req, r0_req}),
      .eligible ({~r1_blocked, 1'b1}),
      .gnt      (gnt)
   );

   assign r0_gnt = gnt[0];
   assign r1_gnt = gnt[1];

   // frame_start wins over a same-cycle conv grant so the new frame starts from zero.
   always_ff @(posedge clk) begin
      if (!reset)                              l0_count <= '0;
      else if (frame_start)                    l0_count <= '0;
      else if (gnt[0] && l0_count != L0_FULL)  l0_count <= l0_count + 1'b1;
   end

   // Strobes are one-cycle pulses; select, addresses and data hold between commands.
   always_ff @(posedge clk) begin
      if (!reset) begin
         csel     <= '0;
         crd      <= 1'b0;
         cwr      <= 1'b0;
         caddr_rd <= '0;
         caddr_wr <= '0;
         cdata_wr <= '0;
      end else begin
         crd <= 1'b0;
         cwr <= 1'b0;
         if (|gnt) begin
            csel <= win_cmd.sel;
            if (win_cmd.we) begin
               cwr      <= 1'b1;
               caddr_wr <= win_cmd.addr;
               cdata_wr <= win_cmd.wdata;
            end else begin
               crd      <= 1'b1;
               caddr_rd <= win_cmd.addr;
            end
         end
      end
   end

   // Only R1 ever reads, so every read strobe returns to the pool engine.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r1_rvalid <= 1'b0;
         r1_rdata  <= '0;
      end else begin
         r1_rvalid <= crd;
         if (crd) r1_rdata <= cdata_rd;
      end
   end

endmodule
